// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states
//   NUM_DIGITS   : digits on the display
//   SEG_LUT      : hex nibble -> abcdefg (bit 6 = a, bit 0 = g), active-high
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } scan_state_t;

    localparam int NUM_DIGITS = 4;

    // Entry 15 first so SEG_LUT[nib] indexes naturally.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to seven-segment pattern.
//   nib : in  4-bit hex digit
//   seg : out abcdefg, active-high, bit 6 = a
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 4-digit seven-segment scan controller.
// Cycles BLANK -> SHOW per digit, PWM-gates the digit enable for brightness,
// optionally suppresses leading zeros, and double-buffers the displayed value
// so a frame is never torn.
//   ledclk     : in  clock
//   rst        : in  async active-high reset
//   en         : in  scan enable; low forces IDLE with outputs off
//   load       : in  strobe, captures value into the shadow register
//   value      : in  16-bit value, digit i = value[4i+3:4i]
//   bright     : in  on-time = (bright+1)/16 of DWELL
//   lz_blank   : in  leading-zero blanking enable
//   abcdefg    : out segments (registered)
//   digit      : out one-hot digit select (registered)
//   frame_done : out one-cycle pulse at end of digit 3 SHOW (registered)
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int BLANK = 2
) (
    input  logic        ledclk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  bright,
    input  logic        lz_blank,
    output logic [6:0]  abcdefg,
    output logic [3:0]  digit,
    output logic        frame_done
);

    // One counter serves both phases, so size it for the longer one.
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int STEP = DWELL / 16;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    scan_state_t state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [15:0] shadow, active;
    logic        pend;

    logic [6:0] abc_n;
    logic [3:0] dig_n;
    logic       fd_n;

    logic [NUM_DIGITS-1:0][6:0] seg_all;
    logic [NUM_DIGITS-1:0]      lz_zero;
    logic [31:0]                on_lim;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_decode u_dec (
            .nib (active[4*i +: 4]),
            .seg (seg_all[i])
        );
    end

    // lz_zero[i]: nibbles i..3 of the active value are all zero.
    // Digit 0 always shows, so its flag is tied low.
    assign lz_zero[0] = 1'b0;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
        assign lz_zero[i] = (active[15:4*i] == '0);
    end

    assign on_lim = (32'(bright) + 32'd1) * 32'(STEP);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        abc_n   = '0;
        dig_n   = '0;
        fd_n    = 1'b0;
        if (!en) begin
            state_n = S_IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = S_SHOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_SHOW: begin
                    // Segments held for the whole dwell; only the digit
                    // enable is PWM-gated.
                    abc_n = (lz_blank && lz_zero[idx]) ? 7'd0 : seg_all[idx];
                    dig_n[idx] = (32'(cnt) < on_lim);
                    if (cnt == DWELL_LAST) begin
                        state_n = S_BLANK;
                        cnt_n   = '0;
                        idx_n   = idx + 2'd1;
                        fd_n    = (idx == 2'd3);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ledclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            abcdefg    <= '0;
            digit      <= '0;
            frame_done <= 1'b0;
            shadow     <= '0;
            active     <= '0;
            pend       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            abcdefg    <= abc_n;
            digit      <= dig_n;
            frame_done <= fd_n;
            if (load) begin
                shadow <= value;
            end
            // Transfer only at the frame boundary. A load in the same cycle
            // lands in shadow after the old shadow moves, keeping pend set.
            if (fd_n && pend) begin
                active <= shadow;
                pend   <= load;
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic        ledclk = 1'b0;
    logic        rst, en, load, lz_blank;
    logic [15:0] value;
    logic [3:0]  bright;
    logic [6:0]  abcdefg;
    logic [3:0]  digit;
    logic        frame_done;

    int npass  = 0;
    int ntotal = 0;

    seg7_scan_ctrl #(.DWELL(16), .BLANK(2)) dut (
        .ledclk     (ledclk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .bright     (bright),
        .lz_blank   (lz_blank),
        .abcdefg    (abcdefg),
        .digit      (digit),
        .frame_done (frame_done)
    );

    always #5 ledclk = ~ledclk;

    typedef struct {
        logic [15:0]      val;
        logic [3:0]       br;
        logic             lz;
        logic [3:0][6:0]  seg;   // {d3, d2, d1, d0}
        int               on;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".abcdefg"}, 32'(abcdefg), 32'd0);
        check({tag, ".digit"}, 32'(digit), 32'd0);
        check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        #1;
        check_zero(tag);
        @(negedge ledclk);
        rst = 1'b0;
    endtask

    task automatic start_with(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge ledclk);
        load = 1'b0;
        en   = 1'b1;
    endtask

    task automatic wait_fd(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge ledclk);
            if (frame_done) ok = 1'b1;
        end
        check({tag, ".wait_fd"}, 32'(ok), 32'd1);
    endtask

    // Entered at the negedge where frame_done is seen. Samples one frame
    // (72 cycles): per digit d, BLANK at offsets 18d+1..18d+2 and SHOW at
    // 18d+3..18d+18; the next frame_done at offset 72. Optional loads are
    // driven right after sampling offset k1/k2.
    task automatic capture(input string tag, input logic [3:0][6:0] es, input int on,
                           input int k1, input logic [15:0] v1,
                           input int k2, input logic [15:0] v2);
        logic [6:0] sa [73];
        logic [3:0] sd [73];
        logic       sf [73];
        int bad, cnt, base;
        logic [3:0] oh;
        for (int k = 1; k <= 72; k++) begin
            @(negedge ledclk);
            load  = 1'b0;
            sa[k] = abcdefg;
            sd[k] = digit;
            sf[k] = frame_done;
            if (k == k1) begin load = 1'b1; value = v1; end
            if (k == k2) begin load = 1'b1; value = v2; end
        end
        bad = 0;
        for (int k = 1; k < 72; k++) if (sf[k]) bad++;
        check({tag, ".fd_early"}, 32'(bad), 32'd0);
        check({tag, ".fd_period"}, 32'(sf[72]), 32'd1);
        bad = 0;
        for (int d = 0; d < 4; d++)
            for (int j = 1; j <= 2; j++)
                if (sa[18*d+j] != 7'd0 || sd[18*d+j] != 4'd0) bad++;
        check({tag, ".blank_gap"}, 32'(bad), 32'd0);
        for (int d = 0; d < 4; d++) begin
            base = 18*d + 3;
            oh   = 4'(1 << d);
            check($sformatf("%s.d%0d.seg", tag, d), 32'(sa[base]), 32'(es[d]));
            bad = 0;
            cnt = 0;
            for (int c = 0; c < 16; c++) begin
                if (sa[base+c] != es[d]) bad++;
                if (sd[base+c] == oh) cnt++;
                if (sd[base+c] != ((c < on) ? oh : 4'd0)) bad++;
            end
            check($sformatf("%s.d%0d.hold_shape", tag, d), 32'(bad), 32'd0);
            check($sformatf("%s.d%0d.on_cycles", tag, d), 32'(cnt), 32'(on));
        end
    endtask

    initial begin
        int bad;
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        value    = '0;
        bright   = 4'd15;
        lz_blank = 1'b0;

        vecs[0] = '{16'h1234, 4'd15, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}, 16};
        vecs[1] = '{16'h0070, 4'd3,  1'b1, {7'h00, 7'h00, 7'h70, 7'h7E}, 4};
        vecs[2] = '{16'h0070, 4'd15, 1'b0, {7'h7E, 7'h7E, 7'h70, 7'h7E}, 16};
        vecs[3] = '{16'h0000, 4'd0,  1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}, 1};
        vecs[4] = '{16'hF0E0, 4'd7,  1'b1, {7'h47, 7'h7E, 7'h4F, 7'h7E}, 8};
        vecs[5] = '{16'h0C05, 4'd11, 1'b1, {7'h00, 7'h4E, 7'h7E, 7'h5B}, 12};

        #1;
        check_zero("reset");
        @(negedge ledclk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset($sformatf("v%0d.rst", i));
            bright   = vecs[i].br;
            lz_blank = vecs[i].lz;
            start_with(vecs[i].val);
            wait_fd($sformatf("v%0d", i));
            capture($sformatf("v%0d", i), vecs[i].seg, vecs[i].on, -1, '0, -1, '0);
        end

        // Tearing: second load mid-frame (digit 1) must not show until next frame.
        do_reset("tear.rst");
        bright   = 4'd15;
        lz_blank = 1'b0;
        start_with(16'hAAAA);
        wait_fd("tear");
        capture("tear.f1", {4{7'h77}}, 16, 25, 16'h5555, -1, '0);
        capture("tear.f2", {4{7'h5B}}, 16, -1, '0, -1, '0);

        // Load coincident with frame_done: prior shadow next, coincident value after.
        do_reset("coin.rst");
        start_with(16'h1111);
        wait_fd("coin");
        capture("coin.f1", {4{7'h30}}, 16, 10, 16'h3333, 71, 16'h2222);
        capture("coin.f2", {4{7'h79}}, 16, -1, '0, -1, '0);
        capture("coin.f3", {4{7'h6D}}, 16, -1, '0, -1, '0);

        // en dropped during SHOW of digit 0.
        do_reset("endrop.rst");
        start_with(16'h1234);
        wait_fd("endrop");
        repeat (8) @(negedge ledclk);
        en = 1'b0;
        @(negedge ledclk);
        check_zero("endrop.next");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ledclk);
            if (frame_done || digit != 4'd0 || abcdefg != 7'd0) bad++;
        end
        check("endrop.idle_quiet", 32'(bad), 32'd0);
        en  = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ledclk);
            if (digit != 4'd0 || abcdefg != 7'd0) bad++;
        end
        check("endrop.reen_blank", 32'(bad), 32'd0);
        @(negedge ledclk);
        check("endrop.reen_digit", 32'(digit), 32'd1);
        check("endrop.reen_seg", 32'(abcdefg), 32'h33);

        // rst asserted mid-BLANK, then released with en still high.
        do_reset("rstb.rst");
        start_with(16'h1234);
        wait_fd("rstb");
        @(negedge ledclk);
        rst = 1'b1;
        #1;
        check_zero("rstb.now");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ledclk);
            if (frame_done || digit != 4'd0 || abcdefg != 7'd0) bad++;
        end
        check("rstb.held", 32'(bad), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ledclk);
            if (digit != 4'd0 || abcdefg != 7'd0) bad++;
        end
        check("rstb.resume_blank", 32'(bad), 32'd0);
        @(negedge ledclk);
        check("rstb.resume_digit", 32'(digit), 32'd1);
        check("rstb.resume_seg", 32'(abcdefg), 32'h7E);

        // rst during SHOW clears outputs without waiting for a clock edge.
        rst = 1'b1;
        #1;
        check_zero("rsts.now");
        @(negedge ledclk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
